// File: rtl/fp_pkg.sv
// Shared floating-point constants and types for the float-to-int conversion path.
package fp_pkg;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RDN = 2'd1;
  localparam logic [1:0] RM_RUP = 2'd2;
  localparam logic [1:0] RM_RTZ = 2'd3;

  localparam int unsigned FP32_BIAS = 127;

  localparam logic [31:0] INT_POS_SAT = 32'h7fff_ffff;
  localparam logic [31:0] INT_NEG_SAT = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StRound,
    StDone
  } f2i_state_e;

endpackage

// File: rtl/f2i_round.sv
// Rounds an aligned magnitude with guard/sticky bits and applies the sign.
module f2i_round
  import fp_pkg::*;
(
  input  logic [31:0] mag_i,
  input  logic        guard_i,
  input  logic        sticky_i,
  input  logic        sign_i,
  input  logic [1:0]  rm_i,
  output logic [31:0] d_o,
  output logic        inexact_o
);

  logic        inc;
  logic [31:0] rounded;

  always_comb begin
    inc = 1'b0;
    unique case (rm_i)
      RM_RNE:  inc = guard_i & (sticky_i | mag_i[0]);
      RM_RDN:  inc = sign_i & (guard_i | sticky_i);
      RM_RUP:  inc = ~sign_i & (guard_i | sticky_i);
      default: inc = 1'b0;
    endcase
    rounded   = mag_i + {31'd0, inc};
    // Negating zero yields zero, so -0 never becomes 0x80000000.
    d_o       = sign_i ? (32'd0 - rounded) : rounded;
    inexact_o = guard_i | sticky_i;
  end

endmodule

// File: rtl/f2i_iter.sv
// Iterative float32 to int32 converter: one bit of right-alignment per cycle,
// valid/ready handshakes on input and output.
module f2i_iter
  import fp_pkg::*;
#(
  parameter int unsigned MAX_RSHIFT = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [1:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        invalid,
  output logic        inexact
);

  localparam int unsigned CntW      = $clog2(MAX_RSHIFT + 1);
  localparam logic [7:0]  ExpLeft   = 8'(FP32_BIAS + 23);
  localparam logic [7:0]  ExpMax    = 8'(FP32_BIAS + 31);
  localparam logic [7:0]  MaxRshift = 8'(MAX_RSHIFT);

  f2i_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     mag_q, mag_d;
  logic            guard_q, guard_d;
  logic            sticky_q, sticky_d;
  logic            sign_q, sign_d;
  logic [1:0]      rm_q, rm_d;
  logic            sat_q, sat_d;
  logic            sat_neg_q, sat_neg_d;
  logic [31:0]     d_q, d_d;
  logic            invalid_q, invalid_d;
  logic            inexact_q, inexact_d;

  logic        s_in;
  logic [7:0]  e_in;
  logic [22:0] frac_in;
  logic [23:0] m_in;
  logic [7:0]  e_eff;
  logic [7:0]  rdist;
  logic [7:0]  lsh;
  logic        is_nan;
  logic        sat_in;

  logic [31:0] rnd_d;
  logic        rnd_inexact;

  always_comb begin
    s_in    = a[31];
    e_in    = a[30:23];
    frac_in = a[22:0];
    m_in    = {e_in != 8'd0, frac_in};
    e_eff   = (e_in == 8'd0) ? 8'd1 : e_in;
    rdist   = ExpLeft - e_eff;
    lsh     = e_in - ExpLeft;
    is_nan  = (e_in == 8'hff) && (frac_in != 23'd0);
    // e = 158 with s = 1 and frac = 0 is exactly -2^31 and stays representable.
    sat_in  = (e_in > ExpMax) ||
              ((e_in == ExpMax) && (!s_in || (frac_in != 23'd0)));
  end

  f2i_round u_round (
    .mag_i     (mag_q),
    .guard_i   (guard_q),
    .sticky_i  (sticky_q),
    .sign_i    (sign_q),
    .rm_i      (rm_q),
    .d_o       (rnd_d),
    .inexact_o (rnd_inexact)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mag_d     = mag_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    sign_d    = sign_q;
    rm_d      = rm_q;
    sat_d     = sat_q;
    sat_neg_d = sat_neg_q;
    d_d       = d_q;
    invalid_d = invalid_q;
    inexact_d = inexact_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d    = s_in;
          rm_d      = rm;
          sat_d     = sat_in;
          sat_neg_d = s_in & ~is_nan;
          guard_d   = 1'b0;
          sticky_d  = 1'b0;
          cnt_d     = '0;
          if (sat_in) begin
            mag_d   = '0;
            state_d = StRound;
          end else if (e_eff >= ExpLeft) begin
            mag_d   = {8'd0, m_in} << lsh[3:0];
            state_d = StRound;
          end else begin
            mag_d   = {8'd0, m_in};
            cnt_d   = CntW'((rdist > MaxRshift) ? MaxRshift : rdist);
            state_d = StShift;
          end
        end
      end
      StShift: begin
        mag_d    = mag_q >> 1;
        guard_d  = mag_q[0];
        sticky_d = sticky_q | guard_q;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) begin
          state_d = StRound;
        end
      end
      StRound: begin
        d_d       = sat_q ? (sat_neg_q ? INT_NEG_SAT : INT_POS_SAT) : rnd_d;
        invalid_d = sat_q;
        inexact_d = sat_q ? 1'b0 : rnd_inexact;
        state_d   = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mag_q     <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      sign_q    <= 1'b0;
      rm_q      <= RM_RNE;
      sat_q     <= 1'b0;
      sat_neg_q <= 1'b0;
      d_q       <= '0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mag_q     <= mag_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      sign_q    <= sign_d;
      rm_q      <= rm_d;
      sat_q     <= sat_d;
      sat_neg_q <= sat_neg_d;
      d_q       <= d_d;
      invalid_q <= invalid_d;
      inexact_q <= inexact_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign d         = d_q;
  assign invalid   = invalid_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_f2i_iter.sv
// Directed self-checking bench for the iterative float32 to int32 converter.
module tb_f2i_iter;

  localparam int Timeout = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [1:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        invalid;
  logic        inexact;

  int checks = 0;
  int errors = 0;

  f2i_iter #(.MAX_RSHIFT(26)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .rm        (rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .invalid   (invalid),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  // Drives one operand, waits for the result, then consumes it.
  task automatic convert(input logic [31:0] av, input logic [1:0] rmv,
                         output logic [31:0] dv, output logic invv,
                         output logic inexv, output int lat);
    in_valid = 1'b1;
    a        = av;
    rm       = rmv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < Timeout) begin
      @(posedge clk);
      #1;
      lat++;
    end
    dv        = d;
    invv      = invalid;
    inexv     = inexact;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || d !== 32'd0 ||
        invalid !== 1'b0 || inexact !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b d=%h inv=%b inx=%b required 1 0 0 0 0",
               in_ready, out_valid, d, invalid, inexact);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] exp_pos [4] = '{32'd568, 32'd568, 32'd569, 32'd568};
    logic [31:0] exp_neg [4] = '{32'hffff_fff8, 32'hffff_fff7, 32'hffff_fff8, 32'hffff_fff8};
    logic [31:0] dv;
    logic        invv, inexv;
    int          lat;
    for (int r = 0; r < 4; r++) begin
      convert(32'h440e11ec, 2'(r), dv, invv, inexv, lat);
      checks++;
      if (dv !== exp_pos[r] || inexv !== 1'b1 || invv !== 1'b0 || lat != 15) begin
        errors++;
        $display("FAIL round_568 rm%0d: got d=%h inx=%b inv=%b lat=%0d required %h 1 0 15",
                 r, dv, inexv, invv, lat, exp_pos[r]);
      end
      convert(32'hc1074bc7, 2'(r), dv, invv, inexv, lat);
      checks++;
      if (dv !== exp_neg[r] || inexv !== 1'b1 || invv !== 1'b0 || lat != 21) begin
        errors++;
        $display("FAIL round_m8456 rm%0d: got d=%h inx=%b inv=%b lat=%0d required %h 1 0 21",
                 r, dv, inexv, invv, lat, exp_neg[r]);
      end
    end
  endtask

  task automatic test_ties();
    logic [31:0] ops [3] = '{32'h40200000, 32'h40600000, 32'hc0200000};
    logic [31:0] exp [3] = '{32'd2, 32'd4, 32'hffff_fffe};
    logic [31:0] dv;
    logic        invv, inexv;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      convert(ops[i], 2'd0, dv, invv, inexv, lat);
      checks++;
      if (dv !== exp[i] || inexv !== 1'b1 || invv !== 1'b0 || lat >= Timeout) begin
        errors++;
        $display("FAIL tie %h: got d=%h inx=%b inv=%b lat=%0d required %h 1 0",
                 ops[i], dv, inexv, invv, lat, exp[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] ops [5] = '{32'hcf000000, 32'h4f000000, 32'h7fc00000,
                             32'hff800000, 32'h4b000001};
    logic [31:0] exp [5] = '{32'h8000_0000, 32'h7fff_ffff, 32'h7fff_ffff,
                             32'h8000_0000, 32'd8388609};
    logic        exp_inv [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] dv;
    logic        invv, inexv;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      convert(ops[i], 2'd0, dv, invv, inexv, lat);
      checks++;
      if (dv !== exp[i] || invv !== exp_inv[i] || inexv !== 1'b0 || lat != 1) begin
        errors++;
        $display("FAIL boundary %h: got d=%h inv=%b inx=%b lat=%0d required %h %b 0 1",
                 ops[i], dv, invv, inexv, lat, exp[i], exp_inv[i]);
      end
    end
  endtask

  task automatic test_tiny();
    logic [31:0] dv;
    logic        invv, inexv;
    int          lat;
    convert(32'h00000001, 2'd2, dv, invv, inexv, lat);
    checks++;
    if (dv !== 32'd1 || inexv !== 1'b1 || lat != 27) begin
      errors++;
      $display("FAIL denorm_rup: got d=%h inx=%b lat=%0d required 1 1 27", dv, inexv, lat);
    end
    convert(32'h00000001, 2'd0, dv, invv, inexv, lat);
    checks++;
    if (dv !== 32'd0 || inexv !== 1'b1 || lat >= Timeout) begin
      errors++;
      $display("FAIL denorm_rne: got d=%h inx=%b lat=%0d required 0 1", dv, inexv, lat);
    end
    convert(32'h80000000, 2'd0, dv, invv, inexv, lat);
    checks++;
    if (dv !== 32'd0 || inexv !== 1'b0 || invv !== 1'b0 || lat >= Timeout) begin
      errors++;
      $display("FAIL neg_zero: got d=%h inx=%b inv=%b lat=%0d required 0 0 0",
               dv, inexv, invv, lat);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    in_valid = 1'b1;
    a        = 32'h4b000001;
    rm       = 2'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_drop: got in_ready=%b required 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < Timeout) begin
      @(posedge clk);
      #1;
      lat++;
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || d !== 32'd8388609) begin
        errors++;
        $display("FAIL hold cycle %0d: got vld=%b rdy=%b d=%h required 1 0 00800001",
                 c, out_valid, in_ready, d);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: got vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] dv;
    logic        invv, inexv;
    int          lat;
    in_valid = 1'b1;
    a        = 32'h440e11ec;
    rm       = 2'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_shift: got vld=%b rdy=%b required 0 0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || d !== 32'd0) begin
      errors++;
      $display("FAIL reset_abort: got vld=%b rdy=%b d=%h required 0 1 0",
               out_valid, in_ready, d);
    end
    convert(32'h40600000, 2'd0, dv, invv, inexv, lat);
    checks++;
    if (dv !== 32'd4 || inexv !== 1'b1 || lat != 23) begin
      errors++;
      $display("FAIL after_reset: got d=%h inx=%b lat=%0d required 4 1 23", dv, inexv, lat);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 32'd0;
    rm        = 2'd0;
    out_ready = 1'b0;
    test_reset();
    test_rounding();
    test_ties();
    test_boundaries();
    test_tiny();
    test_backpressure();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/f2i_iter.md
Name: f2i_iter

Overview:
- Multi-cycle IEEE-754 single-precision to signed 32-bit integer converter (cvt.w.s). It consumes the float results our adder datapath produces and converts them to integers.
- Uses the same 2-bit rm encoding as the float adder.
- Iterative design: one bit of right-alignment per cycle, with a valid/ready handshake on both input and output. Sits between the FP unit result bus and the integer register writeback.

Parameters:
- MAX_RSHIFT, 26, cap on right-shift iterations; any larger shift contributes only sticky bits.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand present
- in_ready  out  1  converter idle, can accept an operand
- a  in  32  float32 operand
- rm  in  2  rounding mode: 0 = nearest-even, 1 = toward -inf, 2 = toward +inf, 3 = toward zero
- out_valid  out  1  result present
- out_ready  in  1  consumer takes the result
- d  out  32  signed integer result
- invalid  out  1  NaN, Inf, or out-of-range operand
- inexact  out  1  discarded fraction bits were nonzero

Behaviour:
- Reset:
  - state = IDLE, in_ready = 1, out_valid = 0, d = 0, invalid = 0, inexact = 0.
  - Any in-flight conversion is discarded.
- Accept: a handshake occurs when in_valid & in_ready. a and rm are registered; in_ready drops the following cycle.
- Decode at accept:
  - s = a[31], e = a[30:23], m = {e != 0, a[22:0]}.
  - Denormals use effective exponent 1.
- Special cases at accept (n = 0, go straight to ROUND):
  - e = 255 (NaN or Inf) → saturate.
  - e > 158 → saturate.
  - e = 158 with s = 0 → saturate.
  - e = 158 with s = 1 and frac != 0 → saturate.
  - Saturation values: NaN and positive overflow → 0x7fffffff; negative overflow → 0x80000000. invalid = 1 in all saturation cases.
- Left path (150 ≤ e ≤ 158): magnitude = m << (e-150), done in the accept cycle. n = 0, guard = sticky = 0.
- Right path (e < 150): n = min(150-e_eff, MAX_RSHIFT).
  - SHIFT state runs n cycles. Each cycle: mag >>= 1, guard = shifted-out bit, sticky |= previous guard.
  - A down-counter tracks remaining shifts.
- FSM: IDLE → (accept) SHIFT if n > 0, else ROUND.
  - SHIFT → SHIFT while count > 1, else ROUND.
  - ROUND → DONE (one cycle).
  - DONE → IDLE on out_ready.
- ROUND: compute inc, then d = s ? -(mag+inc) : (mag+inc), and inexact = guard | sticky.
  - rm 0: inc = g & (st | lsb)
  - rm 1: inc = s & (g | st)
  - rm 2: ~s & (g | st)
  - rm 3: inc = 0
  - Right-path magnitudes are < 2^24, so rounding can never overflow.
- Latency: out_valid rises n+1 cycles after the accept edge, where n is the shift count (n = 0 for left path and special cases).
- DONE:
  - out_valid = 1; d and flags are held stable until out_ready.
  - On the out_ready edge: out_valid = 0 and in_ready = 1 next cycle. There is no same-cycle re-accept.
- Zero (±0) gives d = 0, inexact = 0. -0 gives 0, never 0x80000000.
- rst asserted in any state overrides everything.

Decomposition:
- Shared package fp_pkg:
  - rm encoding constants (RM_RNE, RM_RDN, RM_RUP, RM_RTZ)
  - FSM state enum
  - FP32_BIAS = 127
  - INT_POS_SAT = 0x7fffffff, INT_NEG_SAT = 0x80000000
- One combinational sub-module, f2i_round: takes mag, guard, sticky, sign and rm, and produces d and inexact. It is reusable by a future fixed-point path.

Test Plan:
- 0x440e11ec (568.28), rm 0/1/2/3 → d = 568/568/569/568, inexact = 1, out_valid 15 cycles after accept.
- 0xc1074bc7 (-8.456), rm 0/1/2/3 → d = 0xfffffff8 / 0xfffffff7 / 0xfffffff8 / 0xfffffff8, out_valid 21 cycles after accept.
- Ties under rm 0:
  - 0x40200000 (2.5) → 2.
  - 0x40600000 (3.5) → 4.
  - 0xc0200000 (-2.5) → 0xfffffffe.
  - All inexact = 1.
- Boundaries:
  - 0xcf000000 → 0x80000000, invalid = 0.
  - 0x4f000000 → 0x7fffffff, invalid = 1.
  - 0x7fc00000 (NaN) → 0x7fffffff, invalid = 1.
  - 0x4b000001 → 8388609, n = 0, latency 1.
- Tiny values:
  - 0x00000001 (denormal), rm 2 → 1; rm 0 → 0.
  - 0x80000000 (-0) → 0, inexact = 0.
- Handshake:
  - Hold out_ready = 0 for 5 cycles → d stable, in_ready = 0.
  - Assert rst mid-SHIFT → out_valid = 0 and in_ready = 1 after the next edge; the next conversion is correct.
